uart_fifo_ctrl: RTL and testbench

//  Full-duplex UART controller with parametrised framing, baud divisor and TX/RX FIFOs.
//  It replaces the single-byte send/receive pair and its edge-triggered status latches

---
 rtl/uart_fifo_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: full-duplex UART with TX/RX FIFOs on a single clock.
//
// The CPU side pushes bytes into the TX FIFO and pops received bytes from the
// first-word fall-through RX FIFO. Sticky status flags report dropped RX bytes
// and bad stop bits.
//
// Ports
//   sysclk      system clock for all logic
//   reset       synchronous, active-high; clears every register
//   UART_RX     asynchronous serial input (idle high)
//   UART_TX     serial output (idle high), registered
//   tx_data     byte to queue; bits at or above DATA_BITS are ignored
//   tx_push     enqueue tx_data (ignored while tx_ready is low)
//   tx_ready    TX FIFO not full
//   tx_level    TX FIFO occupancy
//   tx_busy     serialiser active or TX FIFO not empty
//   rx_data     RX FIFO head, zero-extended; 0 while the FIFO is empty
//   rx_valid    RX FIFO not empty
//   rx_pop      discard the RX FIFO head
//   rx_level    RX FIFO occupancy
//   rx_overrun  sticky: a received byte was dropped on a full RX FIFO
//   frame_err   sticky: stop bit sampled low
//   err_clear   clear both sticky flags (wins over a same-cycle set)

// uart_fifo_ctrl_fifo: synchronous FIFO with a registered occupancy count.
//   clk_i/rst_i  clock and synchronous active-high reset
//   push_i/din_i enqueue; accepted when not full, or when full and a pop is
//                accepted in the same cycle
//   pop_i/dout_o dequeue / current head (fall-through)
//   empty_o/full_o/level_o  status derived from the count register
module uart_fifo_ctrl_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dout_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int          AW      = $clog2(DEPTH);
  localparam int unsigned DEPTH_U = DEPTH;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          pop_ok;
  logic          push_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign level_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // A pop on an empty FIFO is dropped; a push on a full FIFO is accepted only
  // when a pop frees the head slot in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH_U; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module uart_fifo_ctrl #(
  parameter int BAUD_DIV  = 10417,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
) (
  input  logic                      sysclk,
  input  logic                      reset,
  input  logic                      UART_RX,
  output logic                      UART_TX,
  input  logic [7:0]                tx_data,
  input  logic                      tx_push,
  output logic                      tx_ready,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic                      tx_busy,
  output logic [7:0]                rx_data,
  output logic                      rx_valid,
  input  logic                      rx_pop,
  output logic [$clog2(RX_DEPTH):0] rx_level,
  output logic                      rx_overrun,
  output logic                      frame_err,
  input  logic                      err_clear
);
  localparam int STOP_LEN = STOP_BITS * BAUD_DIV;
  localparam int CNT_W    = $clog2(STOP_LEN + 1);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_LEN - 1);
  localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);

  // ---------------------------------------------------------------- TX side
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  tx_state_e            tx_state_q;
  logic [CNT_W-1:0]     tx_cnt_q;
  logic [3:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 tx_line_q;

  logic                 tx_full;
  logic                 tx_empty;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_pop;

  uart_fifo_ctrl_fifo #(
    .W     (DATA_BITS),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (sysclk),
    .rst_i   (reset),
    .push_i  (tx_push && !tx_full),
    .din_i   (tx_data[DATA_BITS-1:0]),
    .pop_i   (tx_pop),
    .dout_o  (tx_head),
    .empty_o (tx_empty),
    .full_o  (tx_full),
    .level_o (tx_level)
  );

  assign tx_ready = !tx_full;
  assign tx_busy  = (tx_state_q != TX_IDLE) || !tx_empty;
  assign UART_TX  = tx_line_q;

  // The next byte is fetched on the final stop cycle so frames run back to
  // back with no idle bit in between.
  always_comb begin
    tx_pop = 1'b0;
    if (!tx_empty) begin
      case (tx_state_q)
        TX_IDLE: tx_pop = 1'b1;
        TX_STOP: tx_pop = (tx_cnt_q == STOP_END);
        default: tx_pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_cnt_q <= '0;
          if (tx_pop) begin
            tx_sh_q    <= tx_head;
            tx_line_q  <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_line_q  <= tx_sh_q[0];
            tx_sh_q    <= tx_sh_q >> 1;
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == BIT_LAST) begin
              tx_line_q  <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_bit_q  <= tx_bit_q + 4'd1;
              tx_line_q <= tx_sh_q[0];
              tx_sh_q   <= tx_sh_q >> 1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == STOP_END) begin
            tx_cnt_q <= '0;
            if (tx_pop) begin
              tx_sh_q    <= tx_head;
              tx_line_q  <= 1'b0;
              tx_state_q <= TX_START;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          tx_line_q  <= 1'b1;
          tx_state_q <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX side
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  rx_state_e            rx_state_q;
  logic                 rx_s1_q;
  logic                 rx_s2_q;
  logic                 rx_s3_q;
  logic [CNT_W-1:0]     rx_cnt_q;
  logic [3:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_sh_q;
  logic                 rx_wr_q;
  logic [DATA_BITS-1:0] rx_wr_data_q;
  logic                 overrun_q;
  logic                 ferr_q;

  logic                 rx_full;
  logic                 rx_empty;
  logic [DATA_BITS-1:0] rx_head;
  logic                 stop_sample;
  logic                 ferr_set;
  logic                 overrun_set;

  uart_fifo_ctrl_fifo #(
    .W     (DATA_BITS),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i   (sysclk),
    .rst_i   (reset),
    .push_i  (rx_wr_q),
    .din_i   (rx_wr_data_q),
    .pop_i   (rx_pop),
    .dout_o  (rx_head),
    .empty_o (rx_empty),
    .full_o  (rx_full),
    .level_o (rx_level)
  );

  assign rx_valid   = !rx_empty;
  assign rx_data    = rx_valid ? 8'(rx_head) : '0;
  assign rx_overrun = overrun_q;
  assign frame_err  = ferr_q;

  assign stop_sample = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_END);
  assign ferr_set    = stop_sample && !rx_s2_q;
  // A pop in the same cycle frees the slot, so a full FIFO only overruns
  // when nothing is being popped.
  assign overrun_set = rx_wr_q && rx_full && !rx_pop;

  // rx_s3_q holds the previous synchronised level for falling-edge detection.
  // The mid-bit sample points are measured from the first synchronised low
  // cycle of the start bit.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_s3_q      <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
      rx_wr_q      <= 1'b0;
      rx_wr_data_q <= '0;
    end else begin
      rx_s1_q <= UART_RX;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      rx_wr_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_s3_q && !rx_s2_q) begin
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF_END) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            // High at mid start bit: a glitch, not a frame.
            rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
            if (rx_bit_q == BIT_LAST) begin
              rx_state_q <= RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 4'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q <= '0;
            if (rx_s2_q) begin
              rx_wr_q      <= 1'b1;
              rx_wr_data_q <= rx_sh_q;
            end
            rx_state_q <= RX_WAIT;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RX_WAIT: begin
          // Hold off re-arming until the line is released (covers breaks).
          if (rx_s2_q) begin
            rx_state_q <= RX_IDLE;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else if (err_clear) begin
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      if (overrun_set) overrun_q <= 1'b1;
      if (ferr_set)    ferr_q    <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
module tb_uart_fifo_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       UART_RX;
  logic       UART_TX;
  logic [7:0] tx_data;
  logic       tx_push;
  logic       tx_ready;
  logic [2:0] tx_level;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_pop;
  logic [2:0] rx_level;
  logic       rx_overrun;
  logic       frame_err;
  logic       err_clear;

  int n_total = 0;
  int n_pass  = 0;

  uart_fifo_ctrl #(
    .BAUD_DIV  (16),
    .DATA_BITS (8),
    .STOP_BITS (1),
    .TX_DEPTH  (4),
    .RX_DEPTH  (4)
  ) dut (
    .sysclk     (clk),
    .reset      (reset),
    .UART_RX    (UART_RX),
    .UART_TX    (UART_TX),
    .tx_data    (tx_data),
    .tx_push    (tx_push),
    .tx_ready   (tx_ready),
    .tx_level   (tx_level),
    .tx_busy    (tx_busy),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_pop     (rx_pop),
    .rx_level   (rx_level),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err),
    .err_clear  (err_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tx_push;
    logic [7:0] tx_data;
    logic       rx_pop;
    logic [2:0] e_tx_level;
    logic       e_tx_ready;
    logic [2:0] e_rx_level;
    logic       e_rx_valid;
    logic [7:0] e_rx_data;
  } vec_t;

  vec_t tx_tab[7];
  vec_t rx_tab[5];

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Apply one vector for a cycle, then compare outputs after the edge.
  task automatic apply(input vec_t v, input string tag, input int idx);
    tx_push = v.tx_push;
    tx_data = v.tx_data;
    rx_pop  = v.rx_pop;
    tick();
    tx_push = 1'b0;
    rx_pop  = 1'b0;
    chk($sformatf("%s[%0d].tx_level", tag, idx), tx_level, v.e_tx_level);
    chk($sformatf("%s[%0d].tx_ready", tag, idx), tx_ready, v.e_tx_ready);
    chk($sformatf("%s[%0d].rx_level", tag, idx), rx_level, v.e_rx_level);
    chk($sformatf("%s[%0d].rx_valid", tag, idx), rx_valid, v.e_rx_valid);
    chk($sformatf("%s[%0d].rx_data", tag, idx), rx_data, v.e_rx_data);
  endtask

  task automatic send_bit(input logic b);
    UART_RX = b;
    tick(16);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    UART_RX = 1'b1;
  endtask

  // Decode one TX frame. Entry point is first_wait cycles before the middle
  // of the start bit; exit is the first cycle after the stop bit.
  task automatic decode_tx(input int first_wait, output logic [7:0] b,
                           output logic st, output logic sp);
    tick(first_wait);
    st = UART_TX;
    for (int i = 0; i < 8; i++) begin
      tick(16);
      b[i] = UART_TX;
    end
    tick(16);
    sp = UART_TX;
    tick(9);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       st;
    logic       sp;
    logic [7:0] exp_tx[5];

    //                push  data   pop   txl  rdy  rxl  rxv  rxd
    tx_tab[0] = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 3'd0, 1'b0, 8'h00};
    tx_tab[1] = '{1'b1, 8'h22, 1'b0, 3'd1, 1'b1, 3'd0, 1'b0, 8'h00};
    tx_tab[2] = '{1'b1, 8'h33, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 8'h00};
    tx_tab[3] = '{1'b1, 8'h44, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 8'h00};
    tx_tab[4] = '{1'b1, 8'h55, 1'b0, 3'd4, 1'b0, 3'd0, 1'b0, 8'h00};
    tx_tab[5] = '{1'b1, 8'h66, 1'b0, 3'd4, 1'b0, 3'd0, 1'b0, 8'h00};
    tx_tab[6] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b0, 3'd0, 1'b0, 8'h00};

    rx_tab[0] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd3, 1'b1, 8'h80};
    rx_tab[1] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd2, 1'b1, 8'hFF};
    rx_tab[2] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd1, 1'b1, 8'h5A};
    rx_tab[3] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 8'h00};
    rx_tab[4] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 8'h00};

    exp_tx[0] = 8'h11; exp_tx[1] = 8'h22; exp_tx[2] = 8'h33;
    exp_tx[3] = 8'h44; exp_tx[4] = 8'h55;

    reset = 1'b1; UART_RX = 1'b1; tx_data = '0; tx_push = 1'b0;
    rx_pop = 1'b0; err_clear = 1'b0;
    tick(3);
    reset = 1'b0;
    tick();
    chk("rst.UART_TX", UART_TX, 1'b1);
    chk("rst.tx_busy", tx_busy, 1'b0);
    chk("rst.tx_ready", tx_ready, 1'b1);
    chk("rst.tx_level", tx_level, 3'd0);
    chk("rst.rx_valid", rx_valid, 1'b0);
    chk("rst.rx_data", rx_data, 8'h00);
    chk("rst.rx_level", rx_level, 3'd0);
    chk("rst.rx_overrun", rx_overrun, 1'b0);
    chk("rst.frame_err", frame_err, 1'b0);

    // Single byte 0xA5.
    tx_data = 8'hA5; tx_push = 1'b1;
    tick();
    tx_push = 1'b0;
    chk("t1.line_idle_after_push", UART_TX, 1'b1);
    chk("t1.level_after_push", tx_level, 3'd1);
    chk("t1.busy_after_push", tx_busy, 1'b1);
    tick();
    chk("t1.start_edge", UART_TX, 1'b0);
    chk("t1.level_after_pop", tx_level, 3'd0);
    decode_tx(7, b, st, sp);
    chk("t1.start_bit", st, 1'b0);
    chk("t1.data", b, 8'hA5);
    chk("t1.stop_bit", sp, 1'b1);
    chk("t1.busy_done", tx_busy, 1'b0);
    chk("t1.line_idle_done", UART_TX, 1'b1);
    tick(5);

    // Fill TX FIFO; overflow push ignored; back-to-back frames.
    for (int i = 0; i < 7; i++) apply(tx_tab[i], "t2", i);
    // First start cycle followed tx_tab[1]; now 5 cycles into that start bit.
    for (int k = 0; k < 5; k++) begin
      decode_tx((k == 0) ? 2 : 7, b, st, sp);
      chk($sformatf("t2.f%0d.start", k), st, 1'b0);
      chk($sformatf("t2.f%0d.data", k), b, exp_tx[k]);
      chk($sformatf("t2.f%0d.stop", k), sp, 1'b1);
      chk($sformatf("t2.f%0d.next_line", k), UART_TX, (k < 4) ? 1'b0 : 1'b1);
    end
    chk("t2.busy_done", tx_busy, 1'b0);
    chk("t2.level_done", tx_level, 3'd0);
    tick(20);
    chk("t2.no_sixth_frame", UART_TX, 1'b1);

    // Receive 0x3C and pop it.
    send_frame(8'h3C, 1'b1);
    tick(2);
    chk("t3.rx_valid", rx_valid, 1'b1);
    chk("t3.rx_data", rx_data, 8'h3C);
    chk("t3.rx_level", rx_level, 3'd1);
    chk("t3.frame_err", frame_err, 1'b0);
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    chk("t3.pop_valid", rx_valid, 1'b0);
    chk("t3.pop_level", rx_level, 3'd0);
    chk("t3.pop_data", rx_data, 8'h00);

    // Five frames into a 4-deep RX FIFO.
    send_frame(8'h01, 1'b1);
    send_frame(8'h80, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h5A, 1'b1);
    send_frame(8'hC3, 1'b1);
    tick(2);
    chk("t4.rx_level", rx_level, 3'd4);
    chk("t4.rx_overrun", rx_overrun, 1'b1);
    chk("t4.rx_head", rx_data, 8'h01);
    chk("t4.frame_err", frame_err, 1'b0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("t4.overrun_cleared", rx_overrun, 1'b0);
    chk("t4.level_kept", rx_level, 3'd4);
    for (int i = 0; i < 5; i++) apply(rx_tab[i], "t4drain", i);

    // Bad stop bit, then a short glitch.
    send_frame(8'h55, 1'b0);
    tick(3);
    chk("t5.frame_err", frame_err, 1'b1);
    chk("t5.no_push", rx_level, 3'd0);
    UART_RX = 1'b0;
    tick(3);
    UART_RX = 1'b1;
    tick(200);
    chk("t5.glitch_level", rx_level, 3'd0);
    chk("t5.glitch_ferr", frame_err, 1'b1);
    chk("t5.glitch_overrun", rx_overrun, 1'b0);
    // err_clear held across a bad frame wins over the set.
    err_clear = 1'b1;
    send_frame(8'h55, 1'b0);
    tick(3);
    chk("t5.clear_priority", frame_err, 1'b0);
    err_clear = 1'b0;
    tick(3);
    chk("t5.stays_clear", frame_err, 1'b0);

    // Break: one error, no retrigger while low.
    UART_RX = 1'b0;
    tick(400);
    chk("t5.break_ferr", frame_err, 1'b1);
    chk("t5.break_level", rx_level, 3'd0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    tick(400);
    chk("t5.break_no_retrigger", frame_err, 1'b0);
    UART_RX = 1'b1;
    tick(20);
    send_frame(8'hA3, 1'b1);
    tick(2);
    chk("t5.after_break_data", rx_data, 8'hA3);
    chk("t5.after_break_level", rx_level, 3'd1);

    // Reset in the middle of TX and RX frames.
    tx_data = 8'h0F; tx_push = 1'b1;
    tick();
    tx_data = 8'hF0;
    tick();
    tx_push = 1'b0;
    tick(40);
    UART_RX = 1'b0;
    tick(40);
    chk("t6.pre_tx_busy", tx_busy, 1'b1);
    reset = 1'b1; UART_RX = 1'b1;
    tick();
    chk("t6.UART_TX", UART_TX, 1'b1);
    chk("t6.tx_level", tx_level, 3'd0);
    chk("t6.tx_busy", tx_busy, 1'b0);
    chk("t6.rx_level", rx_level, 3'd0);
    chk("t6.rx_valid", rx_valid, 1'b0);
    reset = 1'b0;
    tick(50);
    chk("t6.tx_stays_idle", UART_TX, 1'b1);
    send_frame(8'h96, 1'b1);
    tick(2);
    chk("t6.rx_data", rx_data, 8'h96);
    chk("t6.rx_level_after", rx_level, 3'd1);
    chk("t6.frame_err", frame_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
